// File: rtl/sample_fifo_spi.sv
// ADC sample FIFO drained oldest-first through a read-only SPI slave (mode 0, MSB first).
// Define SAMPLE_FIFO_DROP_OLDEST_EN to overwrite the oldest sample on a push while full.
module sample_fifo_spi #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              osc_clk,
   input  logic              reset,
   input  logic              write_enable,
   input  logic [7:0]        write_data,
   input  logic              sck,
   input  logic              cs_n,
   output logic              sdo,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              overflow
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

   logic [7:0]        mem_q [DEPTH];
   logic              we_q;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              empty_q;
   logic              overflow_q, overflow_d;
   logic              sck_s1_q, sck_s2_q, sck_s3_q;
   logic              cs_s1_q, cs_s2_q, cs_s3_q;
   state_t            state_q;
   logic [7:0]        shreg_q;
   logic [3:0]        bitcnt_q;
   logic              sdo_q;

   logic       push_c, pop_c, do_pop_c, full_c, has_c, wr_en_c;
   logic       sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c;
   logic [7:0] head_c;

   assign push_c     = write_enable & ~we_q;
   assign sck_rise_c = sck_s2_q & ~sck_s3_q;
   assign sck_fall_c = ~sck_s2_q & sck_s3_q;
   assign cs_rise_c  = cs_s2_q & ~cs_s3_q;
   assign cs_fall_c  = ~cs_s2_q & cs_s3_q;
   assign has_c      = (count_q != CNT_W'(0));
   assign full_c     = (count_q == CNT_W'(DEPTH));
   assign head_c     = has_c ? mem_q[rd_ptr_q] : 8'h00;
   // A chip-select release wins over any load scheduled in the same cycle.
   assign pop_c      = ~cs_rise_c & ((state_q == ST_LOAD) |
                       ((state_q == ST_SHIFT) & sck_fall_c & (bitcnt_q == 4'd8)));
   assign do_pop_c   = pop_c & has_c;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      wr_en_c    = 1'b0;
      if (do_pop_c) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push_c && (!full_c || do_pop_c)) begin
         wr_en_c  = 1'b1;
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (!do_pop_c) count_d = count_q + CNT_W'(1);
      end else if (push_c) begin
         overflow_d = 1'b1;
`ifdef SAMPLE_FIFO_DROP_OLDEST_EN
         wr_en_c  = 1'b1;
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
`endif
      end else if (do_pop_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge osc_clk) begin
      if (wr_en_c) mem_q[wr_ptr_q] <= write_data;
   end

   always_ff @(posedge osc_clk or posedge reset) begin
      if (reset) begin
         we_q       <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_s3_q   <= 1'b0;
         cs_s1_q    <= 1'b1;
         cs_s2_q    <= 1'b1;
         cs_s3_q    <= 1'b1;
      end else begin
         we_q       <= write_enable;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= (count_d == CNT_W'(0));
         overflow_q <= overflow_d;
         sck_s1_q   <= sck;
         sck_s2_q   <= sck_s1_q;
         sck_s3_q   <= sck_s2_q;
         cs_s1_q    <= cs_n;
         cs_s2_q    <= cs_s1_q;
         cs_s3_q    <= cs_s2_q;
      end
   end

   // SPI shifter: sdo is registered alongside shreg so it always mirrors shreg[7] in SHIFT.
   always_ff @(posedge osc_clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         shreg_q  <= 8'h00;
         bitcnt_q <= 4'd0;
         sdo_q    <= 1'b0;
      end else if (cs_rise_c) begin
         state_q  <= ST_IDLE;
         bitcnt_q <= 4'd0;
         sdo_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sdo_q <= 1'b0;
               if (cs_fall_c) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               shreg_q  <= head_c;
               sdo_q    <= head_c[7];
               bitcnt_q <= 4'd0;
               state_q  <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (sck_fall_c) begin
                  if (bitcnt_q == 4'd8) begin
                     shreg_q  <= head_c;
                     sdo_q    <= head_c[7];
                     bitcnt_q <= 4'd0;
                  end else if (bitcnt_q < 4'd8) begin
                     shreg_q <= {shreg_q[6:0], 1'b0};
                     sdo_q   <= shreg_q[6];
                  end
               end else if (sck_rise_c) begin
                  bitcnt_q <= bitcnt_q + 4'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sdo      = sdo_q;
   assign count    = count_q;
   assign empty    = empty_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_fifo_spi.sv
// Directed and randomized bench for sample_fifo_spi against a queue-based FIFO model.
module tb_sample_fifo_spi;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic            osc_clk = 1'b0;
   logic            reset;
   logic            write_enable;
   logic [7:0]      write_data;
   logic            sck;
   logic            cs_n;
   logic            sdo;
   logic [ADDR_W:0] count;
   logic            empty;
   logic            overflow;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mq[$];
   logic       m_ovf;
   logic [7:0] cur_exp;

   sample_fifo_spi #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .osc_clk(osc_clk), .reset(reset), .write_enable(write_enable),
      .write_data(write_data), .sck(sck), .cs_n(cs_n), .sdo(sdo),
      .count(count), .empty(empty), .overflow(overflow)
   );

   always #5 osc_clk = ~osc_clk;

   task automatic tick();
      @(posedge osc_clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain queue with the full-FIFO policy of the active build.
   function automatic void m_push(input logic [7:0] b);
      if (mq.size() == DEPTH) begin
         m_ovf = 1'b1;
`ifdef SAMPLE_FIFO_DROP_OLDEST_EN
         void'(mq.pop_front());
         mq.push_back(b);
`endif
      end else begin
         mq.push_back(b);
      end
   endfunction

   function automatic logic [7:0] m_pop();
      if (mq.size() == 0) return 8'h00;
      return mq.pop_front();
   endfunction

   task automatic check_status(input string tag);
      check({tag, ".count"}, int'(count), mq.size());
      check({tag, ".empty"}, int'(empty), int'(mq.size() == 0));
      check({tag, ".ovf"}, int'(overflow), int'(m_ovf));
   endtask

   task automatic do_reset();
      reset = 1'b1; cs_n = 1'b1; sck = 1'b0; write_enable = 1'b0; write_data = 8'h00;
      repeat (2) tick();
      reset = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      repeat (4) tick();
   endtask

   task automatic push(input logic [7:0] b, input int width);
      write_data = b;
      write_enable = 1'b1;
      repeat (width) tick();
      m_push(b);
      write_enable = 1'b0;
      repeat (2) tick();
   endtask

   task automatic spi_open();
      cs_n = 1'b0;
      cur_exp = m_pop();
      repeat (8) tick();
   endtask

   task automatic spi_bit(output logic b);
      b = sdo;
      sck = 1'b1;
      repeat (8) tick();
      sck = 1'b0;
      repeat (8) tick();
   endtask

   // Eight falls complete a byte; the last one loads the next sample.
   task automatic spi_byte(input string tag);
      logic [7:0] v;
      logic       b;
      for (int i = 0; i < 8; i++) begin
         spi_bit(b);
         v = {v[6:0], b};
      end
      check(tag, int'(v), int'(cur_exp));
      cur_exp = m_pop();
   endtask

   task automatic spi_close();
      cs_n = 1'b1;
      repeat (8) tick();
   endtask

   task automatic spi_read(input string tag, input int n);
      spi_open();
      for (int i = 0; i < n; i++) spi_byte(tag);
      spi_close();
   endtask

   initial begin
      logic b;
      int   nrd;
      do_reset();
      check("rst.sdo", int'(sdo), 0);
      check_status("rst");

      // Basic three-byte burst.
      push(8'h11, 1); push(8'h22, 2); push(8'h33, 3);
      check_status("push3");
      spi_read("burst3", 3);
      check_status("burst3");

      // Long write_enable pulse gives a single push.
      write_data = 8'hA5; write_enable = 1'b1;
      repeat (40) tick();
      m_push(8'hA5);
      write_enable = 1'b0;
      repeat (2) tick();
      check_status("longpulse");
      check("longpulse.cnt1", int'(count), 1);

      // Overfill by two, then drain DEPTH bytes.
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) push(8'(i), 1);
      check_status("overfill");
      check("overfill.ovf1", int'(overflow), 1);
      spi_read("overfill.rd", DEPTH);
      check_status("overfill.rd");

      // Underflow read returns zero without raising a flag.
      do_reset();
      spi_read("under", 1);
      check_status("under");

      // Push coinciding with the pop at cs_n fall while full.
      do_reset();
      for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i), 1);
      cs_n = 1'b0;
      cur_exp = m_pop();
      repeat (3) tick();
      write_data = 8'hC3; write_enable = 1'b1;
      tick();
      m_push(8'hC3);
      write_enable = 1'b0;
      repeat (4) tick();
      check_status("simul");
      check("simul.full", int'(count), DEPTH);
      for (int i = 0; i < DEPTH; i++) spi_byte("simul.rd");
      spi_close();
      check_status("simul.rd");

      // Reset in the middle of a byte.
      push(8'h5A, 1); push(8'h6B, 1);
      spi_open();
      for (int i = 0; i < 4; i++) spi_bit(b);
      reset = 1'b1; cs_n = 1'b1; sck = 1'b0;
      tick();
      mq.delete();
      m_ovf = 1'b0;
      check("midrst.sdo", int'(sdo), 0);
      check_status("midrst");
      reset = 1'b0;
      repeat (4) tick();
      push(8'h77, 1); push(8'h88, 2);
      spi_read("midrst.fresh", 2);
      check_status("midrst.fresh");

      // Randomized pushes and bursts.
      do_reset();
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) != 0) begin
            push(8'($urandom), int'($urandom_range(1, 3)));
         end else begin
            nrd = int'($urandom_range(1, 3));
            spi_read("rand.rd", nrd);
         end
         check_status("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sample_fifo_spi.md
# sample_fifo_spi

Sample buffer between the ADC serial front end and the microcontroller. Captures each 8-bit sample presented on `write_data` when the ADC stage raises `write_enable`, and stores it in a circular FIFO. Serves samples oldest-first to the MCU over a read-only SPI slave port (mode 0, MSB first). Runs entirely on `osc_clk`; the MCU's SPI signals are synchronized internally.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 4.
- `ADDR_W`, 4, log2(`DEPTH`).

- `osc_clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `write_enable`  in  1  sample-valid level from the ADC stage; each rising edge pushes one sample.
- `write_data`  in  8  sample byte; stable while `write_enable` is high.
- `sck`  in  1  MCU SPI clock; asynchronous to `osc_clk`.
- `cs_n`  in  1  MCU chip select, active low; asynchronous.
- `sdo`  out  1  serial data to the MCU.
- `count`  out  `ADDR_W`+1  number of stored samples.
- `empty`  out  1  high when `count` == 0.
- `overflow`  out  1  sticky; set when a sample arrives while the FIFO is full; cleared only by `reset`.

## Operation
- Push detect: register `write_enable` once. Push when the current value is 1 and the registered value is 0. This gives one push per pulse, whatever the pulse width.
- FIFO: `wr_ptr` and `rd_ptr` are `ADDR_W` bits and wrap modulo `DEPTH`. `count` is tracked explicitly.
- SPI synchronization: `sck` and `cs_n` each pass through a 2-flop synchronizer plus an edge-detect register.
- SPI receiver states:
  - IDLE: `cs_n` high. `sdo` = 0.
  - LOAD: on a `cs_n` falling edge, pop the head into an 8-bit shift register and set bit counter = 0. Go to SHIFT.
  - SHIFT: `sdo` = shreg[7].
    - On each `sck` rising edge, increment the bit counter.
    - On each `sck` falling edge with counter < 8, shift shreg left by one.
    - On an `sck` falling edge with counter == 8, pop the next sample into shreg and reset the counter to 0. This supports back-to-back bytes under one `cs_n`.
  - Any state: a `cs_n` rising edge returns to IDLE. A partially shifted byte is discarded, not re-queued.
- Underflow: a load while empty puts 0x00 in shreg. `rd_ptr` and `count` are unchanged, and no flag is raised.
- Simultaneous push and pop: both happen and `count` is unchanged. This holds even when full; `overflow` is not set in that case.
- Push while full with no pop: handled according to `## Configuration`. `overflow` is set.

## Timing
- Reset values: `sdo` = 0, `count` = 0, `empty` = 1, `overflow` = 0. Pointers, shreg and bit counter = 0; state = IDLE; synchronizer flops = 1 for `cs_n` and 0 for `sck`.
- Push latency: the sample is written on the clock edge after `write_enable` is first sampled high. `count` and `empty` update on that same edge.
- SPI latency: 3 `osc_clk` cycles from a pin edge to the internal edge pulse.
  - `sdo` valid ≤ 4 cycles after the `cs_n` fall.
  - `sdo` valid ≤ 4 cycles after each `sck` fall.
- MCU requirements: `sck` high and low phases ≥ 6 `osc_clk` cycles each; `cs_n` setup ≥ 6 cycles before the first `sck` rise.
- `write_data` is sampled on the push cycle only.

## Configuration
- `SAMPLE_FIFO_DROP_OLDEST_EN` defined:
  - A push while full overwrites the oldest entry and advances both `wr_ptr` and `rd_ptr`.
  - `count` stays `DEPTH`.
  - The buffer always holds the newest `DEPTH` samples.
- Undefined (default):
  - A push while full is discarded.
  - Pointers and `count` are unchanged.
- `overflow` is set in both builds.

## Test plan
- After reset, push 0x11, 0x22, 0x33, then one SPI read of 3 bytes under one `cs_n`. Expect `sdo` to stream 0x11, 0x22, 0x33; `count` goes 3→0; `empty` = 1.
- Hold `write_enable` high for 40 cycles with `write_data` = 0xA5. Expect exactly one push (`count` = 1).
- Push `DEPTH`+2 samples 0x00..0x11 with no reads, then read `DEPTH` bytes:
  - Default build: 0x00..0x0F, `overflow` = 1.
  - With the macro: 0x02..0x11, `overflow` = 1.
- Read 1 byte from an empty FIFO. Expect 0x00 on `sdo`, `count` stays 0, `overflow` = 0.
- `DEPTH` samples queued; a push coincides with the pop at `cs_n` fall. Expect `count` to stay `DEPTH`, `overflow` = 0, and no sample lost.
- Assert `reset` after 4 bits of a byte. Expect `sdo` = 0, `count` = 0, state IDLE; the next read after new pushes returns fresh data.
